// File: rtl/bus_rx_queue_if.sv
// bus_rx_queue_if
//   Signal bundle between the shared bus / local consumer and bus_rx_queue.
//   slave  : the receive queue (samples bus + pull, drives status and head entry)
//   master : whatever drives the bus and consumes entries (bench, consumer logic)
//   Bus side      : bus_valid, bus_src[3:0], bus_dest[3:0], bus_data[DATA_W-1:0]
//   Flow control  : free (to the request queue), taken (capture pulse)
//   Consumer side : pull in; valid, empty, src_out, data_out, ovf out
interface bus_rx_queue_if #(
  parameter int DATA_W = 32
);
  logic              bus_valid;
  logic [3:0]        bus_src;
  logic [3:0]        bus_dest;
  logic [DATA_W-1:0] bus_data;
  logic              pull;

  logic              free;
  logic              taken;
  logic              valid;
  logic              empty;
  logic [3:0]        src_out;
  logic [DATA_W-1:0] data_out;
  logic              ovf;

  modport slave (
    input  bus_valid, bus_src, bus_dest, bus_data, pull,
    output free, taken, valid, empty, src_out, data_out, ovf
  );

  modport master (
    output bus_valid, bus_src, bus_dest, bus_data, pull,
    input  free, taken, valid, empty, src_out, data_out, ovf
  );
endinterface

// File: rtl/bus_rx_queue.sv
// bus_rx_queue
//   Destination-side receive queue. Snoops every bus transfer, captures the
//   ones addressed to MY_ID into a DEPTH-entry FIFO of {src, data}, and
//   advertises room through `free` so the sending request queue only grants
//   when a slot exists. A local consumer drains with pull/valid.
//   Ports:
//     clk  - clock, all state on posedge
//     clr  - asynchronous active-low reset
//     bus  - bus_rx_queue_if.slave (bus inputs, pull, free/taken/valid/empty,
//            head entry src_out/data_out, sticky ovf)
module bus_rx_queue #(
  parameter logic [3:0] MY_ID  = 4'h8,
  parameter int         DEPTH  = 4,
  parameter int         DATA_W = 32
) (
  input  logic          clk,
  input  logic          clr,
  bus_rx_queue_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [4+DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;
  logic                ovf_q;
  logic                taken_q;

  logic hit;
  logic push;
  logic pop;
  logic free_c;
  logic valid_c;

  // free looks only at the count register, never at bus or pull, so the
  // request queue sees no combinational path back through this block.
  assign free_c  = (count < DEPTH_C);
  assign valid_c = (count != '0);

  assign hit  = bus.bus_valid && (bus.bus_dest == MY_ID);
  assign push = hit && free_c;
  assign pop  = bus.pull && valid_c;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_q   <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      taken_q <= push;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (hit && !free_c) ovf_q <= 1'b1;
    end
  end

  // Storage carries no reset; clr gates writes so a transfer landing while
  // the queue is held in reset leaves nothing behind.
  always_ff @(posedge clk) begin
    if (push && clr) mem[wr_ptr] <= {bus.bus_src, bus.bus_data};
  end

  assign bus.free     = free_c;
  assign bus.valid    = valid_c;
  assign bus.empty    = !valid_c;
  assign bus.taken    = taken_q;
  assign bus.ovf      = ovf_q;
  assign bus.src_out  = mem[rd_ptr][4+DATA_W-1:DATA_W];
  assign bus.data_out = mem[rd_ptr][DATA_W-1:0];

endmodule
